// File: rtl/sync_fifo_core_if.sv
// sync_fifo_core_if: producer/consumer bundle for sync_fifo_core.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_core_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  we;
    logic                  re;
    logic [DATA_WIDTH-1:0] din;
    logic [DATA_WIDTH-1:0] dout;
    logic                  flagf;
    logic                  flage;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_WIDTH:0]   count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output we, re, din,
        input  dout, flagf, flage, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  we, re, din,
        output dout, flagf, flage, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_core.sv
// sync_fifo_core: single-clock FIFO, registered read port, occupancy count,
// almost-full/almost-empty thresholds and overflow/underflow reporting.
// Optional macro FIFO_STICKY_ERR_EN: overflow/underflow latch until reset;
// without it they pulse for one cycle after each rejected request.
module sync_fifo_core #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 14,
    parameter int AE_LEVEL   = 2
) (
    input  logic clk,
    input  logic rst,
    sync_fifo_core_if.slave bus
);
    localparam int CW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  ovf_q, udf_q;

    logic full, empty, rd_ok, wr_ok, wr_rej, rd_rej;

    // Flags come straight from the registered count.
    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    // A write into a full FIFO is fine when a read frees a slot on the same edge.
    assign rd_ok  = bus.re & ~empty;
    assign wr_ok  = bus.we & (~full | rd_ok);
    assign wr_rej = bus.we & ~wr_ok;
    assign rd_rej = bus.re & ~rd_ok;

    // Storage is not reset; writes are blocked while rst is low.
    always_ff @(posedge clk) begin
        if (wr_ok && rst) mem[wr_ptr] <= bus.din;
    end

    // Pointers, occupancy and the registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout_q <= mem[rd_ptr];
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Error reporting for rejected requests.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
`ifdef FIFO_STICKY_ERR_EN
            ovf_q <= ovf_q | wr_rej;
            udf_q <= udf_q | rd_rej;
`else
            ovf_q <= wr_rej;
            udf_q <= rd_rej;
`endif
        end
    end

    assign bus.dout         = dout_q;
    assign bus.count        = cnt;
    assign bus.flagf        = full;
    assign bus.flage        = empty;
    assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= CW'(AE_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_core.sv
// tb_sync_fifo_core: randomized and directed checks of sync_fifo_core
// against a queue-based reference model.
module tb_sync_fifo_core;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    sync_fifo_core_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo_core #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model
    logic [DW-1:0] q[$];
    logic [DW-1:0] m_dout;
    logic          m_ovf, m_udf;

    task automatic model_clear();
        q.delete();
        m_dout = '0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
    endtask

    // Drive one cycle of requests and advance the model; returns at edge+1.
    task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
        bit rd_ok, wr_ok;
        bus.we  = w;
        bus.re  = r;
        bus.din = d;
        @(posedge clk);
        rd_ok = r && (q.size() != 0);
        wr_ok = w && ((q.size() < DEPTH) || rd_ok);
        if (rd_ok) m_dout = q.pop_front();
        if (wr_ok) q.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
        m_ovf = m_ovf | (w && !wr_ok);
        m_udf = m_udf | (r && !rd_ok);
`else
        m_ovf = w && !wr_ok;
        m_udf = r && !rd_ok;
`endif
        #1;
        bus.we = 1'b0;
        bus.re = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_clear();
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (bus.flage !== 1'b1) $display("FAIL reset_flage got=%b exp=1", bus.flage); else n_pass++;
        n_chk++; if (bus.flagf !== 1'b0) $display("FAIL reset_flagf got=%b exp=0", bus.flagf); else n_pass++;
        n_chk++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_ae got=%b exp=1", bus.almost_empty); else n_pass++;
        n_chk++; if (bus.almost_full !== 1'b0) $display("FAIL reset_af got=%b exp=0", bus.almost_full); else n_pass++;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL reset_count got=%0d exp=0", bus.count); else n_pass++;
        n_chk++; if (bus.dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", bus.dout); else n_pass++;
        n_chk++; if ({bus.overflow, bus.underflow} !== 2'b00)
            $display("FAIL reset_err got=%b%b exp=00", bus.overflow, bus.underflow); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b1, 1'b0, 8'(i));
            n_chk++; if (bus.count !== 5'(i)) $display("FAIL fill_count got=%0d exp=%0d", bus.count, i); else n_pass++;
            n_chk++; if (bus.almost_full !== (i >= AFL)) $display("FAIL fill_af i=%0d got=%b exp=%b", i, bus.almost_full, (i >= AFL)); else n_pass++;
            n_chk++; if (bus.flagf !== (i == DEPTH)) $display("FAIL fill_full i=%0d got=%b exp=%b", i, bus.flagf, (i == DEPTH)); else n_pass++;
        end
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_chk++; if (bus.dout !== 8'(i)) $display("FAIL drain_dout got=%h exp=%h", bus.dout, 8'(i)); else n_pass++;
            n_chk++; if (bus.almost_empty !== ((DEPTH - i) <= AEL))
                $display("FAIL drain_ae i=%0d got=%b exp=%b", i, bus.almost_empty, ((DEPTH - i) <= AEL)); else n_pass++;
        end
        n_chk++; if (bus.flage !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.flage); else n_pass++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i));
        step(1'b1, 1'b0, 8'hAA);
        n_chk++; if (bus.count !== 5'd16) $display("FAIL ovf_count got=%0d exp=16", bus.count); else n_pass++;
        n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_flag got=%b exp=1", bus.overflow); else n_pass++;
        step(1'b0, 1'b0, 8'h00);
`ifdef FIFO_STICKY_ERR_EN
        n_chk++; if (bus.overflow !== 1'b1) $display("FAIL ovf_sticky got=%b exp=1", bus.overflow); else n_pass++;
`else
        n_chk++; if (bus.overflow !== 1'b0) $display("FAIL ovf_pulse got=%b exp=0", bus.overflow); else n_pass++;
`endif
        for (int i = 1; i <= DEPTH; i++) begin
            step(1'b0, 1'b1, 8'h00);
            n_chk++; if (bus.dout !== 8'(i)) $display("FAIL ovf_drain got=%h exp=%h", bus.dout, 8'(i)); else n_pass++;
        end
    endtask

    task automatic test_underflow();
        do_reset();
        step(1'b0, 1'b1, 8'h00);
        n_chk++; if (bus.dout !== 8'h00) $display("FAIL udf_dout got=%h exp=00", bus.dout); else n_pass++;
        n_chk++; if (bus.underflow !== 1'b1) $display("FAIL udf_flag got=%b exp=1", bus.underflow); else n_pass++;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL udf_count got=%0d exp=0", bus.count); else n_pass++;
        step(1'b0, 1'b0, 8'h00);
`ifdef FIFO_STICKY_ERR_EN
        n_chk++; if (bus.underflow !== 1'b1) $display("FAIL udf_sticky got=%b exp=1", bus.underflow); else n_pass++;
`else
        n_chk++; if (bus.underflow !== 1'b0) $display("FAIL udf_pulse got=%b exp=0", bus.underflow); else n_pass++;
`endif
    endtask

    task automatic test_simultaneous();
        logic [DW-1:0] held;
        do_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, 8'(8'h20 + i));
            n_chk++; if (bus.count !== 5'd5) $display("FAIL sim_mid_count got=%0d exp=5", bus.count); else n_pass++;
            n_chk++; if (bus.dout !== 8'(8'h30 + i)) $display("FAIL sim_mid_dout got=%h exp=%h", bus.dout, 8'(8'h30 + i)); else n_pass++;
        end
        for (int i = 0; i < DEPTH - 5; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        step(1'b1, 1'b1, 8'h60);
        n_chk++; if (bus.count !== 5'd16) $display("FAIL sim_full_count got=%0d exp=16", bus.count); else n_pass++;
        n_chk++; if (bus.overflow !== 1'b0) $display("FAIL sim_full_ovf got=%b exp=0", bus.overflow); else n_pass++;
        n_chk++; if (bus.dout !== 8'h34) $display("FAIL sim_full_dout got=%h exp=34", bus.dout); else n_pass++;
        while (q.size() != 0) step(1'b0, 1'b1, 8'h00);
        n_chk++; if (bus.dout !== m_dout) $display("FAIL sim_last_dout got=%h exp=%h", bus.dout, m_dout); else n_pass++;
        held = m_dout;
        step(1'b1, 1'b1, 8'h55);
        n_chk++; if (bus.count !== 5'd1) $display("FAIL sim_empty_count got=%0d exp=1", bus.count); else n_pass++;
        n_chk++; if (bus.underflow !== 1'b1) $display("FAIL sim_empty_udf got=%b exp=1", bus.underflow); else n_pass++;
        n_chk++; if (bus.dout !== held) $display("FAIL sim_empty_dout got=%h exp=%h", bus.dout, held); else n_pass++;
        step(1'b0, 1'b1, 8'h00);
        n_chk++; if (bus.dout !== 8'h55) $display("FAIL sim_readback got=%h exp=55", bus.dout); else n_pass++;
    endtask

    task automatic test_wrap_random();
        int writes = 0;
        logic [3:0] mflags;
        do_reset();
        for (int c = 0; c < 200; c++) begin
            bit w, r;
            w = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 9) < 5);
            if (w) writes++;
            step(w, r, 8'($urandom));
            mflags = {q.size() == DEPTH, q.size() == 0, q.size() >= AFL, q.size() <= AEL};
            n_chk++; if (bus.count !== 5'(q.size())) $display("FAIL rnd_count c=%0d got=%0d exp=%0d", c, bus.count, q.size()); else n_pass++;
            n_chk++; if (bus.dout !== m_dout) $display("FAIL rnd_dout c=%0d got=%h exp=%h", c, bus.dout, m_dout); else n_pass++;
            n_chk++; if ({bus.flagf, bus.flage, bus.almost_full, bus.almost_empty} !== mflags)
                $display("FAIL rnd_flags c=%0d got=%b%b%b%b exp=%b", c, bus.flagf, bus.flage, bus.almost_full, bus.almost_empty, mflags); else n_pass++;
            n_chk++; if ({bus.overflow, bus.underflow} !== {m_ovf, m_udf})
                $display("FAIL rnd_err c=%0d got=%b%b exp=%b%b", c, bus.overflow, bus.underflow, m_ovf, m_udf); else n_pass++;
        end
        n_chk++; if (writes < 2 * DEPTH) $display("FAIL rnd_wrap writes=%0d exp>=%0d", writes, 2 * DEPTH); else n_pass++;
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h70 + i));
        step(1'b0, 1'b1, 8'h00);
        step(1'b1, 1'b0, 8'h77);
        n_chk++; if (bus.count !== 5'd7) $display("FAIL ar_pre_count got=%0d exp=7", bus.count); else n_pass++;
        #2 rst = 1'b0;
        #1;
        n_chk++; if (bus.count !== 5'd0) $display("FAIL ar_count got=%0d exp=0", bus.count); else n_pass++;
        n_chk++; if (bus.flage !== 1'b1) $display("FAIL ar_flage got=%b exp=1", bus.flage); else n_pass++;
        n_chk++; if (bus.dout !== 8'h00) $display("FAIL ar_dout got=%h exp=00", bus.dout); else n_pass++;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        step(1'b1, 1'b0, 8'h99);
        step(1'b0, 1'b1, 8'h00);
        n_chk++; if (bus.dout !== 8'h99) $display("FAIL ar_after got=%h exp=99", bus.dout); else n_pass++;
    endtask

    initial begin
        bus.we  = 1'b0;
        bus.re  = 1'b0;
        bus.din = '0;
        model_clear();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_simultaneous();
        test_wrap_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
